cwm_load_sched: RTL and testbench
=================================

# cwm_load_sched

Ring-buffer load scheduler for the chip weight memory (CWM). Accepts weight-load descriptors (DRAM address, row count) from the instruction layer and splits each into DMA chunks. Chunks are sized by maximum length, CWM wrap boundary and free ring space. Each chunk is issued to the CWM DRAM-to-chip mover as a start pulse, and the scheduler waits for that mover's done pulse before issuing the next. Sits between the instruction decoder and the DRAM-to-chip mover; the CWM consumer's read pointer provides back-pressure.

## Interface
- `CWM_DEPTH`, default 4096: CWM rows; power of two.
- `ROW_BYTES`, default 128: bytes per CWM row (M*4).
- `MAX_CHUNK_ROWS`, default 256: maximum rows per DMA chunk; power of two, ≤ CWM_DEPTH.
- `TIMEOUT_CYCLES`, default 65535: watchdog limit. Used only with the macro.
- AW = $clog2(CWM_DEPTH).

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous active-low reset.
- `clr` in 1: synchronous pulse; zeroes ring pointers. Honoured only in IDLE, otherwise ignored.
- `desc_valid` in 1: descriptor handshake.
- `desc_ready` out 1: descriptor handshake.
- `desc_d_addr` in 32: DRAM byte address.
- `desc_n_rows` in 32: rows to load.
- `desc_done` out 1: one-cycle pulse when a descriptor fully lands.
- `rd_ptr` in AW+1: consumer read pointer, with wrap bit.
- `start_pulse` out 1: to mover.
- `d_addr` out 32: to mover.
- `c_addr` out 32: to mover; zero-extended row index.
- `n_bytes` out 32: to mover.
- `done_pulse` in 1: from mover.
- `wr_ptr_issued` out AW+1: ring write pointer covering completed chunks.
- `busy` out 1: state ≠ IDLE.
- `err` out 1: sticky timeout flag. Constant 0 without the macro.

## Operation
- States: IDLE, CALC, ISSUE, WAIT_DONE.
- IDLE:
  - `desc_ready` = 1.
  - On `desc_valid`, latch `cur_d` ← d_addr and `rem` ← n_rows.
  - If n_rows = 0, pulse `desc_done` next cycle and stay in IDLE. Otherwise go to CALC.
- CALC (one cycle per evaluation), all arithmetic mod 2^(AW+1):
  - used = wr_ptr_issued − rd_ptr; free = CWM_DEPTH − used.
  - to_wrap = CWM_DEPTH − wr_ptr_issued[AW-1:0].
  - want = min(rem, MAX_CHUNK_ROWS, to_wrap).
  - If free ≥ want, register chunk = want and go to ISSUE. Otherwise stay in CALC and re-evaluate every cycle (no partial chunks).
  - used > CWM_DEPTH is illegal consumer behaviour; treat free as 0.
- ISSUE:
  - `start_pulse` = 1 for exactly one cycle.
  - `d_addr` = cur_d, `c_addr` = wr_ptr_issued[AW-1:0], `n_bytes` = chunk*ROW_BYTES.
  - These three outputs hold stable until the next ISSUE.
  - Go to WAIT_DONE.
- WAIT_DONE, on `done_pulse`:
  - wr_ptr_issued += chunk; cur_d += chunk*ROW_BYTES; rem −= chunk.
  - If rem = 0, pulse `desc_done` and go to IDLE. Otherwise go to CALC.
- `done_pulse` outside WAIT_DONE is ignored.
- Wrap: a chunk never crosses row CWM_DEPTH−1. wr_ptr_issued wraps naturally through AW+1 bits.
- Reset mid-operation: all state returns to reset values. The in-flight mover DMA is not cancelled; integration resets both blocks together.

## Timing
- Reset values:
  - `desc_ready` = 1.
  - `desc_done`, `start_pulse`, `busy`, `err` = 0.
  - `d_addr`, `c_addr`, `n_bytes` = 0.
  - `wr_ptr_issued` = 0.
- Descriptor accepted at cycle T (IDLE). CALC at T+1. `start_pulse` at T+2 if space is available.
- `done_pulse` at cycle D gives `desc_done` (last chunk) or CALC (more chunks) at D+1. Next `start_pulse` no earlier than D+2.
- `wr_ptr_issued` updates at D+1, the same cycle as `desc_done`.
- `clr` and `desc_valid` together in IDLE: clr takes effect and the descriptor is also accepted. The first chunk uses the cleared pointer.
- The `rd_ptr` change is seen in the next CALC evaluation; one cycle of slack.

## Configuration
- `CWM_SCHED_TIMEOUT_EN` defined:
  - Counter runs in WAIT_DONE and clears on entry.
  - On reaching TIMEOUT_CYCLES without `done_pulse`: set `err` (sticky until reset or `clr`), go to IDLE, no `desc_done`, pointers unchanged.
- Undefined: no counter; `err` tied to 0; WAIT_DONE waits indefinitely.

## Structure
- Shared package/include:
  - State encoding localparams (IDLE=0, CALC=1, ISSUE=2, WAIT_DONE=3).
  - Ring free-space function, so the consumer-side occupancy checks use the same arithmetic.
- One sub-module `cwm_chunk_calc`: combinational min/free computation, registered once at its output. Keeps the CALC critical path isolated.
- The existing `shift_reg` is not needed.

## Test plan
- DEPTH=4096, MAX=256, rd_ptr=0. Desc {0x1000, 100} → one start: d_addr 0x1000, c_addr 0, n_bytes 12800. done → `desc_done`, wr_ptr_issued=100.
- Desc {0, 600} → chunks of 256, 256, 88 rows at c_addr 0, 256, 512. d_addr steps 32768. `desc_done` only after the third done.
- wr_ptr_issued=4000 (after clr and loads), rd_ptr=4000, desc 200 rows → chunks of 96 rows at c_addr 4000, then 104 at c_addr 0.
- used=4000, desc 200 → stays in CALC with no start. Raise rd_ptr by 256 → start next cycle+1 with 256 rows… clipped to 200.
- n_rows=0 → `desc_done` next cycle, no `start_pulse`. Stray done_pulse in IDLE → no state change.
- With `CWM_SCHED_TIMEOUT_EN`, TIMEOUT=50, no done → `err`=1 at cycle 50 of WAIT_DONE, IDLE, `desc_ready`=1. `rstn` low mid-WAIT_DONE → all outputs at reset values.

Source files
------------

// File: rtl/cwm_load_sched_pkg.sv
// Shared definitions for the CWM load scheduler: state encoding and ring
// free-space arithmetic reused by consumer-side occupancy checks.
package cwm_load_sched_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CALC      = 2'd1;
  localparam logic [1:0] ST_ISSUE     = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    CALC      = ST_CALC,
    ISSUE     = ST_ISSUE,
    WAIT_DONE = ST_WAIT_DONE
  } sched_state_e;

  // Occupancy beyond the ring depth means a misbehaving consumer: report no room.
  function automatic logic [31:0] ring_free(input logic [31:0] used, input logic [31:0] depth);
    return (used > depth) ? 32'd0 : depth - used;
  endfunction

endpackage

// File: rtl/cwm_chunk_calc.sv
// Chunk sizing for the CWM load scheduler: min(remaining, max chunk, rows to wrap)
// checked against ring free space; the chosen size is registered on load.
module cwm_chunk_calc
  import cwm_load_sched_pkg::*;
#(
  parameter  int CWM_DEPTH      = 4096,
  parameter  int MAX_CHUNK_ROWS = 256,
  localparam int AW             = $clog2(CWM_DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [31:0]   rem,
  input  logic [AW:0]   wr_ptr,
  input  logic [AW:0]   rd_ptr,
  output logic          fits,
  output logic [31:0]   want,
  output logic [31:0]   chunk
);

  logic [AW:0] used;
  logic [31:0] free, to_wrap, cap;

  always_comb begin
    used    = wr_ptr - rd_ptr;
    free    = ring_free(32'(used), 32'(CWM_DEPTH));
    to_wrap = 32'(CWM_DEPTH) - 32'(wr_ptr[AW-1:0]);
    cap     = (32'(MAX_CHUNK_ROWS) < to_wrap) ? 32'(MAX_CHUNK_ROWS) : to_wrap;
    want    = (rem < cap) ? rem : cap;
    fits    = (free >= want);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     chunk <= '0;
    else if (load) chunk <= want;
  end

endmodule

// File: rtl/cwm_load_sched.sv
// Ring-buffer weight-load scheduler: splits descriptors into DMA chunks for the
// DRAM-to-chip mover. Optional watchdog under macro CWM_SCHED_TIMEOUT_EN.
module cwm_load_sched
  import cwm_load_sched_pkg::*;
#(
  parameter  int CWM_DEPTH      = 4096,
  parameter  int ROW_BYTES      = 128,
  parameter  int MAX_CHUNK_ROWS = 256,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int AW             = $clog2(CWM_DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          desc_valid,
  output logic          desc_ready,
  input  logic [31:0]   desc_d_addr,
  input  logic [31:0]   desc_n_rows,
  output logic          desc_done,
  input  logic [AW:0]   rd_ptr,
  output logic          start_pulse,
  output logic [31:0]   d_addr,
  output logic [31:0]   c_addr,
  output logic [31:0]   n_bytes,
  input  logic          done_pulse,
  output logic [AW:0]   wr_ptr_issued,
  output logic          busy,
  output logic          err
);

  sched_state_e state, state_nxt;
  logic [31:0]  cur_d, rem, want, chunk;
  logic         fits, last;

  cwm_chunk_calc #(.CWM_DEPTH(CWM_DEPTH), .MAX_CHUNK_ROWS(MAX_CHUNK_ROWS)) u_calc (
    .clk    (clk),
    .rstn   (rstn),
    .load   (state == CALC && fits),
    .rem    (rem),
    .wr_ptr (wr_ptr_issued),
    .rd_ptr (rd_ptr),
    .fits   (fits),
    .want   (want),
    .chunk  (chunk)
  );

  assign last       = (rem == chunk);
  assign desc_ready = (state == IDLE);
  assign busy       = (state != IDLE);

`ifdef CWM_SCHED_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_hit;
  assign to_hit = (state == WAIT_DONE) && !done_pulse && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_DONE) ? to_cnt + 32'd1 : 32'd0;
      if (to_hit)                     err <= 1'b1;
      else if (state == IDLE && clr)  err <= 1'b0;
    end
  end
`else
  logic to_hit;
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (desc_valid && desc_n_rows != 32'd0) state_nxt = CALC;
      CALC:      if (fits) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_pulse) state_nxt = last ? IDLE : CALC;
                 else if (to_hit) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Mover outputs are loaded at the CALC->ISSUE decision so they are valid
  // alongside start_pulse and hold until the next chunk is chosen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_d         <= '0;
      rem           <= '0;
      wr_ptr_issued <= '0;
      start_pulse   <= 1'b0;
      desc_done     <= 1'b0;
      d_addr        <= '0;
      c_addr        <= '0;
      n_bytes       <= '0;
    end else begin
      start_pulse <= 1'b0;
      desc_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) wr_ptr_issued <= '0;
          if (desc_valid) begin
            cur_d <= desc_d_addr;
            rem   <= desc_n_rows;
            if (desc_n_rows == 32'd0) desc_done <= 1'b1;
          end
        end
        CALC: if (fits) begin
          start_pulse <= 1'b1;
          d_addr      <= cur_d;
          c_addr      <= 32'(wr_ptr_issued[AW-1:0]);
          n_bytes     <= want * 32'(ROW_BYTES);
        end
        WAIT_DONE: if (done_pulse) begin
          wr_ptr_issued <= wr_ptr_issued + chunk[AW:0];
          cur_d         <= cur_d + chunk * 32'(ROW_BYTES);
          rem           <= rem - chunk;
          if (last) desc_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cwm_load_sched.sv
module tb_cwm_load_sched;

  localparam int D   = 4096;
  localparam int D2  = 2 * D;
  localparam int MX  = 256;
  localparam int RB  = 128;
  localparam int AW  = 12;

  logic          clk = 1'b0;
  logic          rstn, clr, desc_valid, done_pulse;
  logic [31:0]   desc_d_addr, desc_n_rows;
  logic [AW:0]   rd_ptr;
  logic          desc_ready, desc_done, start_pulse, busy, err;
  logic [31:0]   d_addr, c_addr, n_bytes;
  logic [AW:0]   wr_ptr_issued;

  int checks = 0;
  int errors = 0;
  int m_wp   = 0;
  int m_rd   = 0;

  always #5 clk = ~clk;

  cwm_load_sched #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_d_addr(desc_d_addr), .desc_n_rows(desc_n_rows), .desc_done(desc_done),
    .rd_ptr(rd_ptr), .start_pulse(start_pulse), .d_addr(d_addr), .c_addr(c_addr),
    .n_bytes(n_bytes), .done_pulse(done_pulse), .wr_ptr_issued(wr_ptr_issued),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int m_free();
    int used;
    used = (m_wp - m_rd + D2) % D2;
    return (used > D) ? 0 : D - used;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic set_rd(input int v);
    m_rd   = (v % D2 + D2) % D2;
    rd_ptr = m_rd[AW:0];
  endtask

  task automatic run_desc(input logic [31:0] a, input int n, input bit do_clr);
    int rem, want, cnt;
    bit stalled;
    logic [31:0] cur;
    chk("desc_ready", desc_ready, 1'b1);
    desc_valid  = 1'b1;
    clr         = do_clr;
    desc_d_addr = a;
    desc_n_rows = n;
    if (do_clr) m_wp = 0;
    tick();
    desc_valid = 1'b0;
    clr        = 1'b0;
    if (n == 0) begin
      chk("zero_done", desc_done, 1'b1);
      chk("zero_busy", busy, 1'b0);
      tick();
      chk("zero_done_pulse", desc_done, 1'b0);
      chk("zero_no_start", start_pulse, 1'b0);
      return;
    end
    cur = a;
    rem = n;
    while (rem > 0) begin
      want    = imin(imin(rem, MX), D - (m_wp % D));
      stalled = (m_free() < want);
      if (stalled) begin
        repeat (6) begin
          chk("stall_no_start", start_pulse, 1'b0);
          tick();
        end
        while (m_free() < want) set_rd(m_rd + 256);
      end
      cnt = 0;
      while (!start_pulse && cnt < 20) begin
        tick();
        cnt++;
      end
      chk("start_seen", start_pulse, 1'b1);
      if (!start_pulse) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (!stalled) chk("start_latency", cnt, 1);
      chk("d_addr", d_addr, cur);
      chk("c_addr", c_addr, 32'(m_wp % D));
      chk("n_bytes", n_bytes, 32'(want * RB));
      tick();
      chk("start_one_cycle", start_pulse, 1'b0);
      chk("busy_wait", busy, 1'b1);
      repeat ($urandom_range(0, 4)) tick();
      done_pulse = 1'b1;
      tick();
      done_pulse = 1'b0;
      m_wp = (m_wp + want) % D2;
      cur  = cur + 32'(want * RB);
      rem  = rem - want;
      chk("desc_done", desc_done, (rem == 0));
      chk("wr_ptr", wr_ptr_issued, m_wp[AW:0]);
      chk("output_hold_c", c_addr, 32'((m_wp - want + D2) % D));
      if (rem == 0) begin
        chk("idle_after", busy, 1'b0);
        tick();
        chk("desc_done_pulse", desc_done, 1'b0);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; desc_valid = 1'b0; done_pulse = 1'b0;
    desc_d_addr = '0; desc_n_rows = '0; rd_ptr = '0;
    #12;
    chk("rst_ready", desc_ready, 1'b1);
    chk("rst_done", desc_done, 1'b0);
    chk("rst_start", start_pulse, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_d_addr", d_addr, 32'd0);
    chk("rst_c_addr", c_addr, 32'd0);
    chk("rst_n_bytes", n_bytes, 32'd0);
    chk("rst_wr_ptr", wr_ptr_issued, 13'd0);
    tick();
    rstn = 1'b1;
    tick();

    set_rd(0);
    run_desc(32'h1000, 100, 1'b0);
    run_desc(32'h0, 600, 1'b1);
    run_desc(32'h8000_0000, 3400, 1'b0);
    chk("fill_4000", wr_ptr_issued, 13'd4000);
    set_rd(4000);
    run_desc(32'h20_0000, 200, 1'b0);
    set_rd(m_wp - 4000);
    run_desc(32'h30_0000, 200, 1'b0);
    run_desc(32'h40_0000, 0, 1'b0);

    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
    chk("stray_busy", busy, 1'b0);
    chk("stray_done", desc_done, 1'b0);
    chk("stray_wr_ptr", wr_ptr_issued, m_wp[AW:0]);
    tick();
    chk("stray_no_start", start_pulse, 1'b0);

    for (int i = 0; i < 14; i++) begin
      bit c;
      c = ($urandom_range(0, 3) == 0);
      if (c) set_rd(0);
      else   set_rd(m_wp - int'($urandom_range(0, D)));
      run_desc($urandom, ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 700)), c);
    end
    chk("err_low", err, 1'b0);

    set_rd(m_wp);
    desc_valid = 1'b1; desc_d_addr = 32'hABC0; desc_n_rows = 50;
    tick();
    desc_valid = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", busy, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", desc_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_start", start_pulse, 1'b0);
    chk("mid_rst_d_addr", d_addr, 32'd0);
    chk("mid_rst_n_bytes", n_bytes, 32'd0);
    chk("mid_rst_wr_ptr", wr_ptr_issued, 13'd0);
    tick();
    rstn = 1'b1;
    m_wp = 0;
    set_rd(0);
    tick();
    run_desc(32'h100, 300, 1'b0);

`ifdef CWM_SCHED_TIMEOUT_EN
    begin
      int cnt;
      bit saw_done;
      set_rd(m_wp);
      desc_valid = 1'b1; desc_d_addr = 32'h5000; desc_n_rows = 10;
      tick();
      desc_valid = 1'b0;
      cnt = 0;
      while (!start_pulse && cnt < 20) begin
        tick();
        cnt++;
      end
      chk("to_start", start_pulse, 1'b1);
      tick();
      saw_done = 1'b0;
      repeat (60) begin
        if (desc_done) saw_done = 1'b1;
        tick();
      end
      chk("to_err", err, 1'b1);
      chk("to_ready", desc_ready, 1'b1);
      chk("to_busy", busy, 1'b0);
      chk("to_no_done", saw_done, 1'b0);
      chk("to_wr_ptr", wr_ptr_issued, m_wp[AW:0]);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
